// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - physical register free list with registered rename allocation slots
// Bitmap of free pregs plus per-slot reserved pregs; refill takes successive lowest free bits.

module rename_free_list #(
    parameter int NUM_PREGS     = 128,
    parameter int NUM_ARCH      = 32,
    parameter int PL_WIDTH      = 4,
    parameter int DEALLOC_WIDTH = 4,
    localparam int PREG_W       = $clog2(NUM_PREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_reqs_0,
    input  logic              io_reqs_1,
    input  logic              io_reqs_2,
    input  logic              io_reqs_3,
    output logic              io_alloc_pregs_0_valid,
    output logic [PREG_W-1:0] io_alloc_pregs_0_bits,
    output logic              io_alloc_pregs_1_valid,
    output logic [PREG_W-1:0] io_alloc_pregs_1_bits,
    output logic              io_alloc_pregs_2_valid,
    output logic [PREG_W-1:0] io_alloc_pregs_2_bits,
    output logic              io_alloc_pregs_3_valid,
    output logic [PREG_W-1:0] io_alloc_pregs_3_bits,
    input  logic              io_dealloc_pregs_0_valid,
    input  logic [PREG_W-1:0] io_dealloc_pregs_0_bits,
    input  logic              io_dealloc_pregs_1_valid,
    input  logic [PREG_W-1:0] io_dealloc_pregs_1_bits,
    input  logic              io_dealloc_pregs_2_valid,
    input  logic [PREG_W-1:0] io_dealloc_pregs_2_bits,
    input  logic              io_dealloc_pregs_3_valid,
    input  logic [PREG_W-1:0] io_dealloc_pregs_3_bits,
    output logic [7:0]        io_free_count
);

    localparam logic [NUM_PREGS-1:0] FREE_INIT = {NUM_PREGS{1'b1}} << NUM_ARCH;

    logic [NUM_PREGS-1:0]     free_q;
    logic [NUM_PREGS-1:0]     free_d;
    logic [PL_WIDTH-1:0]      slot_valid_q;
    logic [PL_WIDTH-1:0]      slot_valid_d;
    logic [PREG_W-1:0]        slot_preg_q [PL_WIDTH];
    logic [PREG_W-1:0]        slot_preg_d [PL_WIDTH];

    logic [PL_WIDTH-1:0]      reqs;
    logic [DEALLOC_WIDTH-1:0] dealloc_valid;
    logic [PREG_W-1:0]        dealloc_preg [DEALLOC_WIDTH];

    logic [NUM_PREGS-1:0]     avail;
    logic [NUM_PREGS-1:0]     sel_mask;
    logic [NUM_PREGS-1:0]     dealloc_mask;
    logic                     found;
    logic [PREG_W-1:0]        pick;
    logic [7:0]               count;
    logic [DEALLOC_WIDTH-1:0] dealloc_bad;

    assign reqs          = {io_reqs_3, io_reqs_2, io_reqs_1, io_reqs_0};
    assign dealloc_valid = {io_dealloc_pregs_3_valid, io_dealloc_pregs_2_valid,
                            io_dealloc_pregs_1_valid, io_dealloc_pregs_0_valid};
    assign dealloc_preg[0] = io_dealloc_pregs_0_bits;
    assign dealloc_preg[1] = io_dealloc_pregs_1_bits;
    assign dealloc_preg[2] = io_dealloc_pregs_2_bits;
    assign dealloc_preg[3] = io_dealloc_pregs_3_bits;

    // Each refilling slot sees the bitmap minus whatever lower slots already took.
    always_comb begin
        avail        = free_q;
        sel_mask     = '0;
        dealloc_mask = '0;
        found        = 1'b0;
        pick         = '0;
        for (int i = 0; i < PL_WIDTH; i++) begin
            slot_valid_d[i] = slot_valid_q[i] & ~reqs[i];
            slot_preg_d[i]  = slot_preg_q[i];
            if (!slot_valid_d[i]) begin
                found = 1'b0;
                pick  = '0;
                for (int b = NUM_PREGS - 1; b >= 0; b--) begin
                    if (avail[b]) begin
                        found = 1'b1;
                        pick  = PREG_W'(b);
                    end
                end
                if (found) begin
                    slot_valid_d[i] = 1'b1;
                    slot_preg_d[i]  = pick;
                    avail[pick]     = 1'b0;
                    sel_mask[pick]  = 1'b1;
                end
            end
        end
        for (int j = 0; j < DEALLOC_WIDTH; j++) begin
            if (dealloc_valid[j]) begin
                dealloc_mask[dealloc_preg[j]] = 1'b1;
            end
        end
        free_d = (free_q & ~sel_mask) | dealloc_mask;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_q       <= FREE_INIT;
            slot_valid_q <= '0;
            for (int i = 0; i < PL_WIDTH; i++) begin
                slot_preg_q[i] <= '0;
            end
        end else begin
            free_q       <= free_d;
            slot_valid_q <= slot_valid_d;
            for (int i = 0; i < PL_WIDTH; i++) begin
                slot_preg_q[i] <= slot_preg_d[i];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int b = 0; b < NUM_PREGS; b++) begin
            count = count + {7'd0, free_q[b]};
        end
        for (int i = 0; i < PL_WIDTH; i++) begin
            count = count + {7'd0, slot_valid_q[i]};
        end
    end

    assign io_free_count          = count;
    assign io_alloc_pregs_0_valid = slot_valid_q[0];
    assign io_alloc_pregs_0_bits  = slot_preg_q[0];
    assign io_alloc_pregs_1_valid = slot_valid_q[1];
    assign io_alloc_pregs_1_bits  = slot_preg_q[1];
    assign io_alloc_pregs_2_valid = slot_valid_q[2];
    assign io_alloc_pregs_2_bits  = slot_preg_q[2];
    assign io_alloc_pregs_3_valid = slot_valid_q[3];
    assign io_alloc_pregs_3_bits  = slot_preg_q[3];

    // Freeing a preg that is already free, preg 0, or one still reserved in a slot is a commit bug.
    always_comb begin
        for (int j = 0; j < DEALLOC_WIDTH; j++) begin
            dealloc_bad[j] = dealloc_valid[j] &&
                             (free_q[dealloc_preg[j]] || (dealloc_preg[j] == '0));
            for (int i = 0; i < PL_WIDTH; i++) begin
                if (dealloc_valid[j] && slot_valid_q[i] && (slot_preg_q[i] == dealloc_preg[j])) begin
                    dealloc_bad[j] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < PL_WIDTH; i++) begin : g_req_chk
        a_req_valid: assert property (@(posedge clock) disable iff (reset)
            !(reqs[i] && !slot_valid_q[i]));
    end

    for (genvar j = 0; j < DEALLOC_WIDTH; j++) begin : g_dealloc_chk
        a_dealloc_ok: assert property (@(posedge clock) disable iff (reset)
            !dealloc_bad[j]);
    end

endmodule

// File: doc/rename_free_list.md
RENAME_FREE_LIST -- requirements
Module: rename_free_list

Interface
REQ-001 Parameter NUM_PREGS, 128, number of physical registers; preg index width is 7 bits.
REQ-002 Parameter NUM_ARCH, 32, pregs 0..NUM_ARCH-1 are architecturally mapped at reset and are not free.
REQ-003 Parameter PL_WIDTH, 4, number of rename allocation slots.
REQ-004 Parameter DEALLOC_WIDTH, 4, number of commit-side deallocation ports.
REQ-005 clock  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 io_reqs_0..3  input  1 each  rename slot i consumes its held preg this cycle.
REQ-008 io_alloc_pregs_0..3_valid  output  1 each  slot i holds a reserved preg.
REQ-009 io_alloc_pregs_0..3_bits  output  7 each  preg reserved in slot i; drives the renamer pdst and busy-table rebusy index.
REQ-010 io_dealloc_pregs_0..3_valid  input  1 each  commit frees the preg on port j.
REQ-011 io_dealloc_pregs_0..3_bits  input  7 each  preg being freed on port j.
REQ-012 io_free_count  output  8  total unallocated pregs, counting free bitmap plus valid slots.

Function
REQ-013 State SHALL be a 128-bit free bitmap (1 = free) plus, per slot, a valid bit and a 7-bit preg register.
REQ-014 A preg held in a valid slot SHALL NOT be set in the bitmap (reserved, not free).
REQ-015 Slot outputs SHALL come directly from slot registers (zero combinational path from inputs).
REQ-016 Consume: io_reqs_i && slot i valid SHALL empty slot i at the clock edge.
REQ-017 io_reqs_i with slot i invalid SHALL be ignored and SHALL fire a simulation assertion.
REQ-018 Refill: at each edge, every slot that is invalid or consumed this cycle SHALL load a preg from the current-cycle bitmap.
REQ-019 Refill order: refilling slots in ascending index take successive lowest set bits, so the lowest-index refilling slot gets the lowest free preg and the next gets the next lowest.
REQ-020 If fewer free bits exist than refilling slots, the highest-index refilling slots SHALL stay invalid.
REQ-021 Bits loaded into slots SHALL be cleared in the bitmap at the same edge.
REQ-022 Dealloc: each valid dealloc port SHALL set its bit at the edge.
REQ-023 A preg freed at edge N is not selectable until the refill at edge N+1.
REQ-024 Next bitmap SHALL equal (bitmap & ~selected_mask) | dealloc_mask.
REQ-025 Dealloc of a preg that is already free, of preg < NUM_ARCH at index 0, or of a preg held in a slot SHALL fire an assertion; RTL behaviour is still the set.
REQ-026 Duplicate preg indices across dealloc ports in one cycle SHALL be ORed without error.
REQ-027 io_free_count SHALL equal popcount(bitmap) + number of valid slots, combinational from registers, range 0..96.
REQ-028 Slots not consumed and already valid SHALL hold their preg unchanged.

Reset
REQ-029 While reset is high: bitmap = 1 for pregs NUM_ARCH..127 and 0 for 0..NUM_ARCH-1; all slot valids = 0; no refill; dealloc ignored.
REQ-030 Reset SHALL override any in-flight consume, refill or dealloc in the same cycle.
REQ-031 During reset and in the first cycle after it, io_free_count SHALL read 96 and all io_alloc_pregs_*_valid SHALL read 0.
REQ-032 Reset asserted mid-operation SHALL restore the REQ-029 state at the next edge regardless of prior contents.

Verification
REQ-033 Release reset, idle one cycle -> slots 0..3 = 32,33,34,35 valid; free_count = 96.
REQ-034 Consume all four -> next cycle slots = 36,37,38,39; free_count = 92.
REQ-035 Consume only slot 2 -> slot 2 = 40 (lowest free); slots 0,1,3 unchanged; free_count drops by 1.
REQ-036 Allocate until exhausted, then keep consuming -> all slots invalid; free_count = 0; further reqs fire the assertion only.
REQ-037 With the bitmap empty, dealloc 35 at edge N -> bitmap bit 35 set after N; slot 0 = 35 valid after N+1; free_count = 1 throughout.
REQ-038 With dealloc 50 and 51 and four consumes in the same cycle, then assert reset mid-stream -> state matches REQ-033 after reset release.
